// File: rtl/lly_disp_pkg.sv
// ---------------------------------------------------------------------------
// lly_disp_pkg
//   Shared constants and types for the 8-digit scanned 7-segment display.
//   DIGITS     : number of digits in the display (fixed at 8)
//   SEG_BLANK  : segment pattern for a dark digit
//   SEL_OFF    : digit-select pattern with every digit released
//   SEG_TABLE  : hex nibble -> {dp,g,f,e,d,c,b,a}, active-high, dp=0
//   disp_frame_t : one full display image (nibbles + per-digit blank bits)
// ---------------------------------------------------------------------------
package lly_disp_pkg;

  localparam int DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEL_OFF   = 8'hFF;

  // Entry 15 (F) is the leftmost element, entry 0 the rightmost.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   blank;
  } disp_frame_t;

endpackage

// File: rtl/lly_seg_decode.sv
// ---------------------------------------------------------------------------
// lly_seg_decode
//   Combinational hex-nibble to 7-segment decoder.
//   i_nib : 4-bit hex value
//   o_seg : {dp,g,f,e,d,c,b,a}, active-high; dp is always 0
// ---------------------------------------------------------------------------
module lly_seg_decode
  import lly_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/lly_scan_display.sv
// ---------------------------------------------------------------------------
// lly_scan_display
//   Time-multiplexed 8-digit 7-segment display driver with a tear-free
//   double-buffered image register.
//   Parameters:
//     DIV        : clock cycles each digit is driven (1 .. 2^20-1)
//   Ports:
//     CLK        : system clock, rising edge
//     RST        : asynchronous active-high reset
//     EN         : scan enable; low blanks the display and restarts the scan
//     LOAD       : one-cycle strobe capturing DATA/BLANK
//     DATA       : 8 hex nibbles, DATA[4k+3:4k] is digit k
//     BLANK      : BLANK[k]=1 darkens digit k
//     SEL        : active-low digit select, one bit low at a time
//     SEG        : {dp,g,f,e,d,c,b,a}, active-high
//     SCAN_IDX   : index of the digit currently driven
//     FRAME_DONE : one-cycle pulse on the first cycle of each new frame
// ---------------------------------------------------------------------------
module lly_scan_display
  import lly_disp_pkg::*;
#(
  parameter int unsigned DIV = 50000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     BLANK,
  output logic [DIGITS-1:0]     SEL,
  output logic [7:0]            SEG,
  output logic [2:0]            SCAN_IDX,
  output logic                  FRAME_DONE
);

  localparam logic [19:0] DIV_M1 = 20'(DIV - 1);

  logic [19:0]  r_presc;
  logic [2:0]   r_idx;
  logic         r_wrap_d;
  disp_frame_t  r_disp;
  disp_frame_t  r_pend;
  logic         r_pend_vld;

  logic         w_tick;
  logic         w_wrap;
  logic         w_flush;
  logic [3:0]   w_nib;
  logic         w_blank;
  logic [7:0]   w_dec;

  assign w_tick  = EN && (r_presc == DIV_M1);
  assign w_wrap  = w_tick && (r_idx == 3'd7);
  // The image may change whenever no digit of a frame is mid-display:
  // at the frame wrap, or any time the scan is stopped.
  assign w_flush = w_wrap || !EN;

  assign w_nib   = r_disp.data[{r_idx, 2'b00} +: 4];
  assign w_blank = r_disp.blank[r_idx];

  lly_seg_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_dec)
  );

  // Scan timing and registered outputs. Outputs follow r_idx by one cycle,
  // so each digit still spans exactly DIV cycles on the pins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_wrap_d   <= 1'b0;
      SEL        <= SEL_OFF;
      SEG        <= SEG_BLANK;
      SCAN_IDX   <= '0;
      FRAME_DONE <= 1'b0;
    end else if (!EN) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_wrap_d   <= 1'b0;
      SEL        <= SEL_OFF;
      SEG        <= SEG_BLANK;
      SCAN_IDX   <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      r_presc    <= w_tick ? '0 : r_presc + 20'd1;
      if (w_tick)
        r_idx    <= r_idx + 3'd1;
      r_wrap_d   <= w_wrap;
      SEL        <= ~(8'(1) << r_idx);
      SEG        <= w_blank ? SEG_BLANK : w_dec;
      SCAN_IDX   <= r_idx;
      // Lands on the same edge that first drives digit 0 of the new frame.
      FRAME_DONE <= r_wrap_d;
    end
  end

  // Image double buffer. A LOAD coinciding with a flush bypasses the
  // pending register so the freshest data is never held back a frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_disp     <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else if (w_flush && LOAD) begin
      r_disp     <= '{data: DATA, blank: BLANK};
      r_pend_vld <= 1'b0;
    end else begin
      if (LOAD) begin
        r_pend     <= '{data: DATA, blank: BLANK};
        r_pend_vld <= 1'b1;
      end
      if (w_flush && r_pend_vld) begin
        r_disp     <= r_pend;
        r_pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lly_scan_display.sv
// ---------------------------------------------------------------------------
// tb_lly_scan_display
//   Self-checking bench: a DIV=4 instance carries the scan/load scenarios,
//   a DIV=1 instance (same inputs) covers single-cycle slots and async reset.
// ---------------------------------------------------------------------------
module tb_lly_scan_display;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        LOAD = 1'b0;
  logic [31:0] DATA = '0;
  logic [7:0]  BLANK = '0;

  logic [7:0] sel4, seg4, sel1, seg1;
  logic [2:0] idx4, idx1;
  logic       fd4, fd1;

  always #5 CLK = ~CLK;

  lly_scan_display #(.DIV(4)) u_d4 (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .DATA(DATA), .BLANK(BLANK),
    .SEL(sel4), .SEG(seg4), .SCAN_IDX(idx4), .FRAME_DONE(fd4)
  );

  lly_scan_display #(.DIV(1)) u_d1 (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .DATA(DATA), .BLANK(BLANK),
    .SEL(sel1), .SEG(seg1), .SCAN_IDX(idx1), .FRAME_DONE(fd1)
  );

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] seg;
    logic       fd;
    logic [2:0] idx;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          n = 0;           // edges since the scan was (re)started
  logic [31:0] cur_d = '0;      // image the model expects on the display
  logic [7:0]  cur_b = '0;
  logic        cur_en = 1'b0;

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 8'h3F; 4'h1: return 8'h06; 4'h2: return 8'h5B; 4'h3: return 8'h4F;
      4'h4: return 8'h66; 4'h5: return 8'h6D; 4'h6: return 8'h7D; 4'h7: return 8'h07;
      4'h8: return 8'h7F; 4'h9: return 8'h6F; 4'hA: return 8'h77; 4'hB: return 8'h7C;
      4'hC: return 8'h39; 4'hD: return 8'h5E; 4'hE: return 8'h79; default: return 8'h71;
    endcase
  endfunction

  // Expected outputs after the nn-th enabled edge.
  function automatic exp_t model(input int nn, input int dv, input logic [31:0] d,
                                 input logic [7:0] b, input logic en);
    exp_t e;
    int   dg;
    if (!en) begin
      e = '{sel: 8'hFF, seg: 8'h00, fd: 1'b0, idx: 3'd0};
    end else begin
      dg    = ((nn - 1) / dv) % 8;
      e.sel = ~(8'h01 << dg);
      e.seg = b[dg] ? 8'h00 : seg_of(d[dg*4 +: 4]);
      e.fd  = (nn > 1) && (((nn - 1) % (8 * dv)) == 0);
      e.idx = 3'(dg);
    end
    return e;
  endfunction

  task automatic run_cycles(input int cnt, input int which, input string tag);
    int   dv;
    exp_t e, g;
    dv = (which == 1) ? 1 : 4;
    for (int i = 1; i <= cnt; i++)
      sb.push_back(model(n + i, dv, cur_d, cur_b, cur_en));
    for (int i = 0; i < cnt; i++) begin
      @(posedge CLK); #1;
      n++;
      g = (which == 1) ? {sel1, seg1, fd1, idx1} : {sel4, seg4, fd4, idx4};
      e = sb.pop_front();
      tests_run++;
      if (g.sel !== e.sel) begin
        tests_failed++;
        $display("FAIL %s n=%0d SEL got %h want %h", tag, n, g.sel, e.sel);
      end
      tests_run++;
      if (g.seg !== e.seg) begin
        tests_failed++;
        $display("FAIL %s n=%0d SEG got %h want %h", tag, n, g.seg, e.seg);
      end
      tests_run++;
      if (g.fd !== e.fd) begin
        tests_failed++;
        $display("FAIL %s n=%0d FRAME_DONE got %b want %b", tag, n, g.fd, e.fd);
      end
      tests_run++;
      if (g.idx !== e.idx) begin
        tests_failed++;
        $display("FAIL %s n=%0d SCAN_IDX got %0d want %0d", tag, n, g.idx, e.idx);
      end
      tests_run++;
      if ($countones(~g.sel) > 1) begin
        tests_failed++;
        $display("FAIL %s n=%0d onehot SEL got %h want at most one low bit", tag, n, g.sel);
      end
    end
  endtask

  task automatic pulse_load(input logic [31:0] d, input logic [7:0] b, input string tag);
    LOAD = 1'b1; DATA = d; BLANK = b;
    run_cycles(1, 0, tag);
    LOAD = 1'b0;
  endtask

  task automatic test_reset();
    cur_en = 1'b0;
    run_cycles(2, 0, "reset_d4");
    run_cycles(1, 1, "reset_d1");
    RST = 1'b0; EN = 1'b1; cur_en = 1'b1; n = 0;
  endtask

  task automatic test_idle_scan();
    run_cycles(64, 0, "idle");                   // edges 1..64, all zeros
  endtask

  task automatic test_load_midframe();
    run_cycles(6, 0, "mid_pre");                 // 65..70
    pulse_load(32'h76543210, 8'h00, "mid_ld");   // 71
    run_cycles(25, 0, "mid_old");                // 72..96, old frame intact
    cur_d = 32'h76543210; cur_b = 8'h00;
    run_cycles(31, 0, "mid_new");                // 97..127
  endtask

  task automatic test_load_on_wrap();
    pulse_load(32'hFEDCBA98, 8'h00, "wrap_ld");  // 128 is the wrap edge
    cur_d = 32'hFEDCBA98;
    run_cycles(32, 0, "wrap_new");               // 129..160
  endtask

  task automatic test_blank();
    run_cycles(4, 0, "blk_pre");                 // 161..164
    pulse_load(32'h88888888, 8'b1000_0001, "blk_ld");
    run_cycles(27, 0, "blk_old");                // 166..192
    cur_d = 32'h88888888; cur_b = 8'b1000_0001;
    run_cycles(32, 0, "blk_new");                // 193..224
  endtask

  task automatic test_en_drop();
    run_cycles(14, 0, "en_pre");                 // 225..238: SEL=F7, 2 into slot
    EN = 1'b0; cur_en = 1'b0;
    run_cycles(1, 0, "en_off");
    pulse_load(32'h76543210, 8'h00, "en_off_ld");
    run_cycles(2, 0, "en_off_hold");
    cur_d = 32'h76543210; cur_b = 8'h00;
    EN = 1'b1; cur_en = 1'b1; n = 0;
    run_cycles(32, 0, "en_restart");
  endtask

  task automatic test_back_to_back();
    run_cycles(3, 0, "b2b_pre");
    pulse_load(32'h11111111, 8'h00, "b2b_ld1");
    run_cycles(2, 0, "b2b_mid");
    pulse_load(32'hABCDEF01, 8'h10, "b2b_ld2");
    run_cycles(25, 0, "b2b_old");                // through edge 64
    cur_d = 32'hABCDEF01; cur_b = 8'h10;
    run_cycles(32, 0, "b2b_new");
  endtask

  task automatic test_div1_async();
    RST = 1'b1; cur_en = 1'b0;
    run_cycles(1, 1, "d1_rst");
    RST = 1'b0; cur_en = 1'b1; n = 0; cur_d = '0; cur_b = '0;
    run_cycles(16, 1, "d1_scan");
    #2; RST = 1'b1; #1;                          // between clock edges
    tests_run++;
    if (sel1 !== 8'hFF) begin
      tests_failed++;
      $display("FAIL async_rst SEL got %h want ff", sel1);
    end
    tests_run++;
    if (idx1 !== 3'd0) begin
      tests_failed++;
      $display("FAIL async_rst SCAN_IDX got %0d want 0", idx1);
    end
    tests_run++;
    if (seg1 !== 8'h00 || sel4 !== 8'hFF) begin
      tests_failed++;
      $display("FAIL async_rst SEG1/SEL4 got %h/%h want 00/ff", seg1, sel4);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load_midframe();
    test_load_on_wrap();
    test_blank();
    test_en_drop();
    test_back_to_back();
    test_div1_async();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard leftover got %0d want 0", sb.size());
    end
    #20;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
